// File: rtl/baud_pkg.sv
// Shared constants for the fractional baud generator: reset divisor, divisor
// struct and the 32-entry baud table (48 MHz SCLK, 16x oversampling).
package baud_pkg;

  localparam int TBL_DIV_W  = 16;
  localparam int TBL_FRAC_W = 4;

  localparam logic [TBL_DIV_W-1:0] DIV_RST = 16'd8;

  typedef struct packed {
    logic [TBL_DIV_W-1:0]  div_int;
    logic [TBL_FRAC_W-1:0] div_frac;
  } baud_div_t;

  // Unused modes fall back to the reset divisor.
  function automatic baud_div_t baud_table(input logic [4:0] bmode);
    baud_div_t entry;
    entry = '{DIV_RST, 4'd0};
    case (bmode)
      5'd0:  entry = '{16'd10000, 4'd0};
      5'd1:  entry = '{16'd5000,  4'd0};
      5'd2:  entry = '{16'd2500,  4'd0};
      5'd3:  entry = '{16'd1250,  4'd0};
      5'd4:  entry = '{16'd625,   4'd0};
      5'd5:  entry = '{16'd312,   4'd8};
      5'd6:  entry = '{16'd208,   4'd5};
      5'd7:  entry = '{16'd156,   4'd4};
      5'd8:  entry = '{16'd104,   4'd3};
      5'd9:  entry = '{16'd78,    4'd2};
      5'd10: entry = '{16'd52,    4'd1};
      5'd11: entry = '{16'd39,    4'd1};
      5'd12: entry = '{16'd26,    4'd1};
      5'd13: entry = '{16'd13,    4'd0};
      5'd14: entry = '{16'd12,    4'd0};
      5'd15: entry = '{16'd6,     4'd8};
      5'd16: entry = '{16'd6,     4'd0};
      5'd17: entry = '{16'd3,     4'd4};
      5'd18: entry = '{16'd3,     4'd0};
      5'd19: entry = '{16'd2,     4'd0};
      5'd20: entry = '{16'd2,     4'd0};
      default: entry = '{DIV_RST, 4'd0};
    endcase
    return entry;
  endfunction

endpackage

// File: rtl/baud_frac_core.sv
// Cycle counter plus fractional accumulator; produces the oversample tick.
// os_fire is the combinational "tick at this edge" used by the phase logic.
module baud_frac_core #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              sclk,
  input  logic              sclr,
  input  logic              run,
  input  logic              sync_clr,
  input  logic [DIV_W-1:0]  adiv,
  input  logic [FRAC_W-1:0] afrac,
  output logic              os_fire,
  output logic              os_tick
);

  localparam int CW = DIV_W + 1;

  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              stretch;
  logic [CW-1:0]     eff_div;
  logic [CW-1:0]     last_cnt;
  logic [FRAC_W:0]   acc_sum;

  // Compare with >= so a divisor shrunk while frozen cannot strand cnt past the end.
  always_comb begin
    eff_div  = (adiv < DIV_W'(2)) ? CW'(2) : {1'b0, adiv};
    last_cnt = eff_div + CW'(stretch) - CW'(1);
    acc_sum  = {1'b0, acc} + {1'b0, afrac};
    os_fire  = run && !sync_clr && ({1'b0, cnt} >= last_cnt);
  end

  always_ff @(posedge sclk or posedge sclr) begin
    if (sclr) begin
      cnt     <= '0;
      acc     <= '0;
      stretch <= 1'b0;
      os_tick <= 1'b0;
    end else begin
      os_tick <= os_fire;
      if (sync_clr) begin
        cnt     <= '0;
        acc     <= '0;
        stretch <= 1'b0;
      end else if (os_fire) begin
        cnt     <= '0;
        acc     <= acc_sum[FRAC_W-1:0];
        stretch <= acc_sum[FRAC_W];
      end else if (run) begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/frac_baud_gen.sv
// Fractional baud generator top: phase counter, mid/baud decode, divisor load.
// Define BAUD_GEN_TABLE_EN to replace DIV_IN/FRAC_IN with a BMODE table select.
module frac_baud_gen
  import baud_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR    = 16
) (
  input  logic              SCLK,
  input  logic              SCLR,
  input  logic              EN,
  input  logic              SYNC_CLR,
  input  logic              DIV_LD,
`ifdef BAUD_GEN_TABLE_EN
  input  logic [4:0]        BMODE,
`else
  input  logic [DIV_W-1:0]  DIV_IN,
  input  logic [FRAC_W-1:0] FRAC_IN,
`endif
  output logic              OS_TICK,
  output logic              MID_TICK,
  output logic              BAUD_TICK,
  output logic              LD_PEND
);

  localparam int              PH_W    = $clog2(OSR);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PH_PMID = PH_W'(OSR / 2 - 1);

  logic              armed;
  logic              run;
  logic              os_fire;
  logic              os_tick_q;
  logic              mid_tick_q;
  logic              baud_tick_q;
  logic              wrap;
  logic              apply_pend;
  logic [PH_W-1:0]   phase;
  logic [DIV_W-1:0]  adiv;
  logic [FRAC_W-1:0] afrac;
  logic [DIV_W-1:0]  pend_div;
  logic [FRAC_W-1:0] pend_frac;
  logic              ld_pend;
  logic [DIV_W-1:0]  cap_div;
  logic [FRAC_W-1:0] cap_frac;

`ifdef BAUD_GEN_TABLE_EN
  baud_div_t tbl_entry;
  always_comb begin
    tbl_entry = baud_table(BMODE);
    cap_div   = DIV_W'(tbl_entry.div_int);
    cap_frac  = FRAC_W'(tbl_entry.div_frac);
  end
`else
  always_comb begin
    cap_div  = DIV_IN;
    cap_frac = FRAC_IN;
  end
`endif

  // armed holds off counting for one edge after reset release.
  assign run        = EN && armed;
  assign wrap       = os_fire && (phase == PH_LAST);
  assign apply_pend = ld_pend && (wrap || !EN);

  baud_frac_core #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_core (
    .sclk     (SCLK),
    .sclr     (SCLR),
    .run      (run),
    .sync_clr (SYNC_CLR),
    .adiv     (adiv),
    .afrac    (afrac),
    .os_fire  (os_fire),
    .os_tick  (os_tick_q)
  );

  always_ff @(posedge SCLK or posedge SCLR) begin
    if (SCLR) begin
      armed       <= 1'b0;
      phase       <= '0;
      mid_tick_q  <= 1'b0;
      baud_tick_q <= 1'b0;
    end else begin
      armed       <= 1'b1;
      mid_tick_q  <= os_fire && (phase == PH_PMID);
      baud_tick_q <= wrap;
      if (SYNC_CLR) begin
        phase <= '0;
      end else if (os_fire) begin
        phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      end
    end
  end

  // A load landing on the boundary edge stays pending; the older value applies.
  always_ff @(posedge SCLK or posedge SCLR) begin
    if (SCLR) begin
      adiv      <= DIV_W'(DIV_RST);
      afrac     <= '0;
      pend_div  <= '0;
      pend_frac <= '0;
      ld_pend   <= 1'b0;
    end else begin
      if (apply_pend) begin
        adiv  <= pend_div;
        afrac <= pend_frac;
      end
      if (DIV_LD) begin
        pend_div  <= cap_div;
        pend_frac <= cap_frac;
        ld_pend   <= 1'b1;
      end else if (apply_pend) begin
        ld_pend <= 1'b0;
      end
    end
  end

  // Gated with EN so a tick registered just before EN falls is not seen.
  assign OS_TICK   = os_tick_q   && EN;
  assign MID_TICK  = mid_tick_q  && EN;
  assign BAUD_TICK = baud_tick_q && EN;
  assign LD_PEND   = ld_pend;

endmodule

// File: tb/tb_frac_baud_gen.sv
// Directed bench for frac_baud_gen (default build, DIV_RST = 8, OSR = 16).
module tb_frac_baud_gen;

  logic        SCLK = 1'b0;
  logic        SCLR;
  logic        EN;
  logic        SYNC_CLR;
  logic        DIV_LD;
  logic [15:0] DIV_IN;
  logic [3:0]  FRAC_IN;
  logic        OS_TICK;
  logic        MID_TICK;
  logic        BAUD_TICK;
  logic        LD_PEND;

  int vectors     = 0;
  int miscompares = 0;
  int seen;

  always #5 SCLK = ~SCLK;

  frac_baud_gen #(
    .DIV_W  (16),
    .FRAC_W (4),
    .OSR    (16)
  ) dut (
    .SCLK      (SCLK),
    .SCLR      (SCLR),
    .EN        (EN),
    .SYNC_CLR  (SYNC_CLR),
    .DIV_LD    (DIV_LD),
    .DIV_IN    (DIV_IN),
    .FRAC_IN   (FRAC_IN),
    .OS_TICK   (OS_TICK),
    .MID_TICK  (MID_TICK),
    .BAUD_TICK (BAUD_TICK),
    .LD_PEND   (LD_PEND)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Counts negedges until the selected tick (0=OS, 1=MID, 2=BAUD) is seen; -1 on timeout.
  task automatic waitTick(input int sel, input int budget, output int cycles);
    cycles = -1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge SCLK);
      if ((sel == 0 && OS_TICK) || (sel == 1 && MID_TICK) || (sel == 2 && BAUD_TICK)) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic expectPeriod(input string tag, input int sel, input int expected);
    int c;
    waitTick(sel, expected + 50, c);
    checkOutput(tag, c, expected);
  endtask

  // One-cycle DIV_LD pulse issued at a negedge; LD_PEND must be up one edge later.
  task automatic applyStimulus(input logic [15:0] div, input logic [3:0] frac, input string tag);
    DIV_IN  = div;
    FRAC_IN = frac;
    DIV_LD  = 1'b1;
    @(negedge SCLK);
    DIV_LD  = 1'b0;
    checkOutput(tag, int'(LD_PEND), 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    SCLR = 1'b1; EN = 1'b0; SYNC_CLR = 1'b0; DIV_LD = 1'b0;
    DIV_IN = 16'd10; FRAC_IN = 4'd0;
    repeat (3) @(negedge SCLK);
    EN = 1'b1;
    @(negedge SCLK);
    checkOutput("rst_outputs", int'({OS_TICK, MID_TICK, BAUD_TICK, LD_PEND}), 0);

    // Release: one arming edge, then DIV_RST = 8 cycles.
    SCLR = 1'b0;
    expectPeriod("rst_first_os", 0, 9);
    expectPeriod("rst_div_period", 0, 8);

    // Divisor 10: applied at the next boundary (tick 16 of the 8-cycle run).
    applyStimulus(16'd10, 4'd0, "ld10_pend");
    expectPeriod("ld10_boundary", 2, 111);
    checkOutput("ld10_pend_clr", int'(LD_PEND), 0);
    expectPeriod("div10_os", 0, 10);
    expectPeriod("div10_mid", 1, 70);
    expectPeriod("div10_mid_to_baud", 2, 80);
    expectPeriod("div10_baud", 2, 160);

    // Load 20 at phase 5.
    for (int i = 0; i < 5; i++) expectPeriod("div10_os_pre", 0, 10);
    applyStimulus(16'd20, 4'd0, "ld20_pend");
    expectPeriod("ld20_boundary", 2, 109);
    checkOutput("ld20_pend_clr", int'(LD_PEND), 0);
    expectPeriod("div20_os", 0, 20);
    expectPeriod("div20_baud_rest", 2, 300);

    // 10 + 8/16: periods 10,10,11,10,11... first baud 167, then 168.
    applyStimulus(16'd10, 4'd8, "frac_pend");
    expectPeriod("frac_boundary", 2, 319);
    expectPeriod("frac_os1", 0, 10);
    expectPeriod("frac_os2", 0, 10);
    expectPeriod("frac_os3", 0, 11);
    expectPeriod("frac_baud_first", 2, 136);
    expectPeriod("frac_baud_168", 2, 168);

    // SYNC_CLR 37 cycles into a baud period.
    repeat (36) @(negedge SCLK);
    SYNC_CLR = 1'b1;
    @(negedge SCLK);
    SYNC_CLR = 1'b0;
    checkOutput("sync_no_tick", int'({OS_TICK, MID_TICK, BAUD_TICK}), 0);
    expectPeriod("sync_first_os", 0, 10);
    expectPeriod("sync_phase_restart", 2, 157);

    // EN low for 50 cycles, 4 cycles into an 11-cycle period.
    repeat (4) @(negedge SCLK);
    EN = 1'b0;
    seen = 0;
    repeat (50) begin
      @(negedge SCLK);
      if (OS_TICK || MID_TICK || BAUD_TICK) seen++;
    end
    checkOutput("en_low_ticks", seen, 0);
    EN = 1'b1;
    expectPeriod("en_resume", 0, 7);

    // Asynchronous reset while a tick and a pending load are visible.
    applyStimulus(16'd1, 4'd0, "ld1_pend_pre_rst");
    expectPeriod("pre_rst_os", 0, 9);
    checkOutput("pre_rst_state", int'({OS_TICK, LD_PEND}), 3);
    #2 SCLR = 1'b1;
    #1 checkOutput("rst_async", int'({OS_TICK, MID_TICK, BAUD_TICK, LD_PEND}), 0);
    repeat (2) @(negedge SCLK);
    SCLR = 1'b0;
    expectPeriod("rst2_first_os", 0, 9);
    expectPeriod("rst2_div_period", 0, 8);

    // DIV_IN = 1 clamps to a 2-cycle period.
    applyStimulus(16'd1, 4'd0, "ld1_pend");
    expectPeriod("ld1_boundary", 2, 111);
    expectPeriod("clamp_os1", 0, 2);
    expectPeriod("clamp_os2", 0, 2);

    // SYNC_CLR and DIV_LD together: restart now, new divisor at next boundary.
    DIV_IN = 16'd10; FRAC_IN = 4'd0;
    SYNC_CLR = 1'b1; DIV_LD = 1'b1;
    @(negedge SCLK);
    SYNC_CLR = 1'b0; DIV_LD = 1'b0;
    checkOutput("sync_ld_state", int'({OS_TICK, LD_PEND}), 1);
    expectPeriod("sync_ld_os", 0, 2);
    expectPeriod("sync_ld_boundary", 2, 30);
    expectPeriod("sync_ld_new_div", 0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
